// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the 2-read / 1-write register file.
//   RF_DATA_W    : default register width in bits
//   RF_NUM_REGS  : number of entries (fixed at 32, matches the 5-bit address)
//   RF_ADDR_W    : address width of the write and read ports
//   RF_RESET_VAL : value every entry takes on reset
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_DATA_W    = 32;
  localparam int RF_NUM_REGS  = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_RESET_VAL = 0;

endpackage : regfile_pkg

// File: rtl/register32.sv
// ---------------------------------------------------------------------------
// register32
// One register-file entry: a DATA_W-bit register with write enable and an
// asynchronous active-low clear.
// Ports:
//   clock        : rising-edge clock
//   ctrl_reset_n : asynchronous active-low clear to RF_RESET_VAL
//   wr_en        : load d at the next rising edge
//   d            : data to load
//   q            : stored value
// ---------------------------------------------------------------------------
module register32
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      q <= DATA_W'(RF_RESET_VAL);
    end else if (wr_en) begin
      q <= d;
    end
  end

endmodule : register32

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
// 32-entry register file with two combinational read ports and one
// synchronous write port. Entry 0 is hardwired to zero.
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a read that
// addresses the entry being written in the same cycle returns the write data
// (write-first). Address 0 is never bypassed. Default build: no bypass, the
// read returns the pre-write value.
// Ports:
//   clock            : sole clock, all state updates on its rising edge
//   ctrl_reset_n     : asynchronous active-low reset, clears every entry
//   ctrl_writeEnable : write strobe
//   ctrl_writeReg    : write address
//   data_writeReg    : write data
//   ctrl_readRegA/B  : read addresses for ports A and B
//   data_readRegA/B  : read data for ports A and B
// ---------------------------------------------------------------------------
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 ctrl_writeEnable,
  input  logic [RF_ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0]    data_writeReg,
  input  logic [RF_ADDR_W-1:0] ctrl_readRegA,
  input  logic [RF_ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0]    data_readRegA,
  output logic [DATA_W-1:0]    data_readRegB
);

  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   entry_q [NUM_REGS];
  logic                unused_wr_sel0;

  // One-hot write select. Bit 0 decodes but drives no storage, so writes to
  // address 0 are discarded.
  always_comb begin
    wr_sel = '0;
    if (ctrl_writeEnable) begin
      wr_sel[ctrl_writeReg] = 1'b1;
    end
  end

  assign unused_wr_sel0 = wr_sel[0];

  assign entry_q[0] = DATA_W'(RF_RESET_VAL);

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    register32 #(
      .DATA_W (DATA_W)
    ) u_entry (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .wr_en        (wr_sel[i]),
      .d            (data_writeReg),
      .q            (entry_q[i])
    );
  end

  // Two independent 32:1 read multiplexers.
  always_comb begin
    data_readRegA = entry_q[ctrl_readRegA];
    data_readRegB = entry_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    // Write-first forwarding; suppressed during reset so reads stay at zero.
    if (ctrl_reset_n && ctrl_writeEnable && (ctrl_writeReg != '0)) begin
      if (ctrl_readRegA == ctrl_writeReg) begin
        data_readRegA = data_writeReg;
      end
      if (ctrl_readRegB == ctrl_writeReg) begin
        data_readRegB = data_writeReg;
      end
    end
`endif
  end

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        clk_run;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int checks = 0;
  int errors = 0;

  regfile_2r1w #(
    .DATA_W   (32),
    .NUM_REGS (32)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  // Clock only toggles once clk_run is set, so the reset check sees no edge.
  initial begin
    clock = 1'b0;
    forever begin
      #5;
      if (clk_run) clock = ~clock;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Expected read data is what the ports show before the vector's edge.
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5,
                BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
    vecs[1] = '{1'b0, 5'd5, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd0,
                BYP ? 32'h11111111 : 32'h0, 32'h0};
    vecs[5] = '{1'b1, 5'd7, 32'h22222222, 5'd7, 5'd5,
                BYP ? 32'h22222222 : 32'h11111111, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 5'd7, 32'h33333333, 5'd7, 5'd7, 32'h22222222, 32'h22222222};
    vecs[7] = '{1'b0, 5'd9, 32'h12345678, 5'd9, 5'd7, 32'h0,        32'h22222222};
    vecs[8] = '{1'b0, 5'd9, 32'h0,        5'd9, 5'd9, 32'h0,        32'h0};

    clk_run          = 1'b0;
    ctrl_reset_n     = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;

    // Reset with no clock edge: every address reads zero on both ports.
    #2;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      check($sformatf("reset_a[%0d]", i), data_readRegA, 32'h0);
      check($sformatf("reset_b[%0d]", 31 - i), data_readRegB, 32'h0);
    end
    ctrl_reset_n = 1'b1;
    #1;
    clk_run = 1'b1;
    tick();

    // Table-driven vectors.
    for (int v = 0; v < 9; v++) begin
      ctrl_writeEnable = vecs[v].we;
      ctrl_writeReg    = vecs[v].wa;
      data_writeReg    = vecs[v].wd;
      ctrl_readRegA    = vecs[v].ra;
      ctrl_readRegB    = vecs[v].rb;
      #1;
      check($sformatf("vec%0d_a", v), data_readRegA, vecs[v].ea);
      check($sformatf("vec%0d_b", v), data_readRegB, vecs[v].eb);
      tick();
    end

    // Fill 1..31 with address * 0x01010101.
    for (int i = 1; i < 32; i++) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'(i);
      data_writeReg    = 32'(i) * 32'h01010101;
      tick();
    end
    // Write disabled while data and addresses toggle.
    ctrl_writeEnable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ctrl_writeReg = 5'(c * 11 + 3);
      data_writeReg = (c % 2 == 0) ? 32'hFFFFFFFF : 32'h5A5A5A5A;
      ctrl_readRegA = 5'(c + 1);
      ctrl_readRegB = 5'(30 - c);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      check($sformatf("hold_a[%0d]", i), data_readRegA, 32'(i) * 32'h01010101);
      check($sformatf("hold_b[%0d]", 31 - i), data_readRegB, 32'(31 - i) * 32'h01010101);
    end

    // Fill 31, then pulse reset between edges.
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd31;
    data_writeReg    = 32'hA5A5A5A5;
    tick();
    ctrl_writeEnable = 1'b0;
    ctrl_readRegA    = 5'd31;
    ctrl_readRegB    = 5'd5;
    #1;
    check("fill31", data_readRegA, 32'hA5A5A5A5);
    // A write is pending when reset hits; it must be dropped.
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd4;
    data_writeReg    = 32'hBADC0DE0;
    #1;
    ctrl_reset_n = 1'b0;
    #1;
    check("async_clr_a31", data_readRegA, 32'h0);
    check("async_clr_b5", data_readRegB, 32'h0);
    // Writes during reset are ignored, including across an edge.
    ctrl_readRegB = 5'd4;
    tick();
    check("rst_wr_ignored_b4", data_readRegB, 32'h0);
    check("rst_hold_a31", data_readRegA, 32'h0);
    // Release between edges; the first edge after release writes.
    ctrl_writeReg = 5'd3;
    data_writeReg = 32'hCAFEF00D;
    ctrl_readRegA = 5'd3;
    #2;
    ctrl_reset_n = 1'b1;
    #1;
    check("post_rst_pre_edge_a3", data_readRegA, BYP ? 32'hCAFEF00D : 32'h0);
    tick();
    ctrl_writeEnable = 1'b0;
    #1;
    check("first_write_a3", data_readRegA, 32'hCAFEF00D);
    check("aborted_b4", data_readRegB, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_2r1w
